// File: rtl/silife_control_regs.sv
// silife_control_regs
// Run-control register block for the cell grid. Decodes the loader's control
// write port into enable/wrap/period/limit registers, paces generation steps
// with a programmable down-counter, and hands each step to the grid through a
// one-deep pending slot released by i_step_ready.
//
// Optional feature macro: SILIFE_CTRL_READBACK_EN
//   Defined   : adds i_rd_addr / o_rd_data, a registered read port (1-cycle latency).
//   Undefined : the block is write-only and those ports do not exist.

module silife_control_regs #(
    parameter int STEP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_write,
    input  logic [23:0]          i_addr,
    input  logic [31:0]          i_data,
    input  logic                 i_step_ready,
    output logic                 o_enable,
    output logic                 o_wrap,
    output logic                 o_step,
    output logic [STEP_BITS-1:0] o_step_count,
    output logic                 o_overrun
`ifdef SILIFE_CTRL_READBACK_EN
    ,
    input  logic [23:0]          i_rd_addr,
    output logic [31:0]          o_rd_data
`endif
);

    localparam logic [23:0] ADDR_CTRL   = 24'h000000;
    localparam logic [23:0] ADDR_PERIOD = 24'h000001;
    localparam logic [23:0] ADDR_LIMIT  = 24'h000002;
    localparam logic [23:0] ADDR_COUNT  = 24'h000003;

    localparam logic [STEP_BITS-1:0] COUNT_ONE = STEP_BITS'(1);
    localparam logic [STEP_BITS-1:0] COUNT_MAX = '1;

    // Architectural state
    logic                 enable_q;
    logic                 wrap_q;
    logic                 overrun_q;
    logic                 pending_q;
    logic [23:0]          period_q;
    logic [23:0]          timer_q;
    logic [STEP_BITS-1:0] limit_q;
    logic [STEP_BITS-1:0] count_q;

    // Next-state values
    logic                 enable_d;
    logic                 wrap_d;
    logic                 overrun_d;
    logic                 pending_d;
    logic [23:0]          period_d;
    logic [23:0]          timer_d;
    logic [STEP_BITS-1:0] limit_d;
    logic [STEP_BITS-1:0] count_d;

    // Decoded events for the current cycle
    logic                 ctrl_wr;
    logic                 period_wr;
    logic                 limit_wr;
    logic                 step_req;
    logic                 clear_req;
    logic                 enable_rise;
    logic                 expire;
    logic                 issue;
    logic                 auto_stop;
    logic [23:0]          new_period;
    logic [STEP_BITS-1:0] count_inc;

    // Decode the write port and derive the per-cycle step events
    always_comb begin
        ctrl_wr     = i_write && (i_addr == ADDR_CTRL);
        period_wr   = i_write && (i_addr == ADDR_PERIOD);
        limit_wr    = i_write && (i_addr == ADDR_LIMIT);
        step_req    = ctrl_wr && i_data[2];
        clear_req   = ctrl_wr && i_data[3];
        enable_rise = ctrl_wr && i_data[0] && !enable_q;
        new_period  = (i_data[23:0] == 24'd0) ? 24'd1 : i_data[23:0];
        expire      = enable_q && (timer_q == 24'd0);
        issue       = pending_q && i_step_ready && !reset;
        count_inc   = (count_q == COUNT_MAX) ? count_q : (count_q + COUNT_ONE);
        auto_stop   = issue && !clear_req && (limit_q != '0) && (count_inc == limit_q);
    end

    // Next-state logic for the register file, timer, pending slot and counters
    always_comb begin
        wrap_d    = wrap_q;
        period_d  = period_q;
        limit_d   = limit_q;
        enable_d  = enable_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        count_d   = count_q;

        if (ctrl_wr) begin
            wrap_d = i_data[1];
        end
        if (period_wr) begin
            period_d = new_period;
        end
        if (limit_wr) begin
            limit_d = i_data[STEP_BITS-1:0];
        end

        // A CTRL write overrides the auto-stop landing in the same cycle.
        if (ctrl_wr) begin
            enable_d = i_data[0];
        end else if (auto_stop) begin
            enable_d = 1'b0;
        end

        // Reloads take precedence over expiry; a frozen timer holds its value.
        if (enable_rise) begin
            timer_d = period_q - 24'd1;
        end else if (period_wr && enable_q) begin
            timer_d = new_period - 24'd1;
        end else if (expire) begin
            timer_d = period_q - 24'd1;
        end else if (enable_q) begin
            timer_d = timer_q - 24'd1;
        end

        // One-deep slot: expiry and single-step merge; an issue frees it.
        pending_d = (pending_q && !issue) || expire || step_req;

        if (clear_req) begin
            overrun_d = 1'b0;
        end else if (expire && pending_q && !issue) begin
            overrun_d = 1'b1;
        end

        if (clear_req) begin
            count_d = '0;
        end else if (issue) begin
            count_d = count_inc;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;
            pending_q <= 1'b0;
            period_q  <= 24'd1;
            timer_q   <= 24'd0;
            limit_q   <= '0;
            count_q   <= '0;
        end else begin
            enable_q  <= enable_d;
            wrap_q    <= wrap_d;
            overrun_q <= overrun_d;
            pending_q <= pending_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
        end
    end

    // Drive outputs; the step pulse is the issue event itself
    always_comb begin
        o_enable     = enable_q;
        o_wrap       = wrap_q;
        o_overrun    = overrun_q;
        o_step_count = count_q;
        o_step       = issue;
    end

`ifdef SILIFE_CTRL_READBACK_EN
    // Registered read mux over the control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rd_data <= 32'd0;
        end else begin
            case (i_rd_addr)
                ADDR_CTRL:   o_rd_data <= {overrun_q, 29'd0, wrap_q, enable_q};
                ADDR_PERIOD: o_rd_data <= {8'd0, period_q};
                ADDR_LIMIT:  o_rd_data <= 32'(limit_q);
                ADDR_COUNT:  o_rd_data <= 32'(count_q);
                default:     o_rd_data <= 32'd0;
            endcase
        end
    end
`endif

endmodule
